wired_icache_refill: RTL
========================

Name: wired_icache_refill

Overview:
- Bus-side responder for the instruction cache's miss and uncached-fetch request port (lsu_bus_req_t in, lsu_bus_resp_t out).
- Cached requests (inv_req == RD_ALLOC): fetches the 16-byte line over an AXI4 read channel, installs data and tag into the way-selected SRAMs, and returns the requested doubleword.
- Uncached requests: performs a 1- or 2-beat single read and returns the data without installing anything.
- The SRAM write command doubles as the dsram_snoop_t broadcast that the fetch pipeline uses to forward in-flight updates.

Parameters:
- AXI_ID, 4'd0: ARID driven on every request.
- WAY_CNT, 4: cache associativity; the victim counter is log2(WAY_CNT) bits wide.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, rst_n is asynchronous and active-low.
- bus_req_i  in  lsu_bus_req_t  request. Fields used: valid, target_paddr[31:0], size[1:0], inv_req, uncached_load_req.
- bus_resp_o  out  lsu_bus_resp_t  response. Fields used: ready (1-cycle pulse), rdata[1:0][31:0].
- snoop_o  out  dsram_snoop_t  SRAM write and snoop broadcast. Fields: daddr[11:0], dway[1:0], dwe, d[3:0][31:0], taddr[11:0], twe[3:0], t (cache_tag_t: p[19:0], rp).
- araddr_o  out  32  AXI read address.
- arlen_o  out  8  AXI burst length.
- arsize_o  out  3  AXI beat size.
- arburst_o  out  2  AXI burst type.
- arid_o  out  4  AXI read ID.
- arvalid_o  out  1  AXI read-address valid.
- arready_i  in  1  AXI read-address ready.
- rdata_i  in  32  AXI read data.
- rresp_i  in  2  AXI read response.
- rlast_i  in  1  AXI last beat.
- rvalid_i  in  1  AXI read-data valid.
- rready_o  out  1  AXI read-data ready.

Behaviour:
- Reset state: fsm=S_IDLE, victim counter=0, line buffer=0, beat counter=0. All outputs reset to 0: arvalid_o, rready_o, bus_resp_o.ready, every snoop_o write enable.
- Requester contract: bus_req_i is held stable while valid until the cycle after ready. No request is accepted in the cycle ready is high.
- S_IDLE
  - bus_req_i.valid with inv_req==RD_ALLOC: latch the request, go to S_AR.
  - Cached AR: araddr={paddr[31:4],4'h0}, arlen=3, arsize=2, arburst=INCR.
  - bus_req_i.valid with uncached_load_req: latch the request, go to S_AR.
  - Uncached AR: araddr=paddr. size==3 gives arlen=1, otherwise arlen=0. arsize=2, arburst=INCR.
  - Neither request type asserted: stay in S_IDLE.
- S_AR: arvalid_o=1, with address fields from registers. On arready_i, go to S_R.
- S_R: rready_o=1. Each rvalid_i beat writes word[beat] and increments beat (2 bits, wraps).
  - Cached burst: beat counter starts at 0.
  - Uncached burst: beat counter starts at paddr[2] and writes into the returned doubleword.
  - Any rresp_i!=OKAY sets a sticky err flag.
  - On rvalid_i&&rlast_i: go to S_WB if cached, S_RESP if uncached.
  - rlast_i arriving early or late is not checked; the beat counter wraps.
- S_WB (1 cycle, cached only):
  - snoop_o.daddr = taddr = {paddr[11:4],4'h0}.
  - dway = tway = victim; dwe=1; d = line buffer.
  - twe = one-hot(victim); t.p = paddr[31:12]; t.rp = !err.
  - The victim counter increments (mod WAY_CNT) at the end of this cycle. Go to S_RESP.
- S_RESP (1 cycle): bus_resp_o.ready=1, err cleared, go to S_IDLE.
  - Cached: rdata = {word[{paddr[3],1}], word[{paddr[3],0}]}.
  - Uncached: rdata = {word[1], word[0]} of the requested doubleword.
- Outside S_WB, all snoop_o enables are 0. daddr and taddr hold their last value so comparators do not toggle.
- Latency (AR accepted immediately, R back-to-back): cached = 1 AR + 4 R + 1 WB + 1 RESP = 7 cycles after acceptance. Uncached 1-beat = 3 cycles.
- Async reset mid-burst: the FSM aborts to S_IDLE. The AXI fabric shares rst_n, so no orphaned beats remain.

Decomposition:
- wired0_defines package holds lsu_bus_req_t, lsu_bus_resp_t, dsram_snoop_t, cache_tag_t, and RD_ALLOC.
- New in the package: icache_refill_fsm_t (S_IDLE, S_AR, S_R, S_WB, S_RESP) and AXI constants (BURST_INCR=2'b01, RESP_OKAY=2'b00).
- Single module; no sub-module is warranted.

Test Plan:
- Cached miss, paddr=0x1C00_0018, beats 0xA0,0xA1,0xA2,0xA3:
  - araddr=0x1C00_0010, arlen=3.
  - WB cycle: daddr=0x010, twe=4'b0001, t.p=0x1C000, rp=1.
  - rdata={0xA3,0xA2}, ready pulses exactly 1 cycle, 7 cycles after valid.
- Four consecutive cached misses: twe=0001, 0010, 0100, 1000; the fifth miss wraps to 0001.
- Uncached, size=2, paddr=0x8000_0004, beat 0x55:
  - arlen=0, araddr=0x8000_0004, rdata[1]=0x55.
  - No snoop enable asserted.
  - Uncached, size=3, paddr=0x8000_0000, beats 0x11,0x22: arlen=1, rdata={0x22,0x11}.
- Backpressure: arready_i low 5 cycles, then rvalid_i gapped every other cycle. arvalid_o stays high until accepted, beats are captured only on rvalid_i, and the final data is unchanged.
- rresp=SLVERR on beat 2 of a cached burst: WB still occurs with t.rp=0, ready pulses, and the next miss has err cleared.
- rst_n asserted in S_R after 2 beats: all outputs are 0 immediately (asynchronous). After release, a new request completes normally with victim=0.

Source files
------------

// File: rtl/wired0_defines.sv
// Shared LSU bus, cache SRAM snoop and AXI definitions for the wired0 core.
// Also holds the state encoding of the instruction-cache refill engine.
package wired0_defines;

  localparam logic [1:0] RD_ALLOC   = 2'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef struct packed {
    logic        valid;
    logic [31:0] target_paddr;
    logic [1:0]  size;
    logic [1:0]  inv_req;
    logic        uncached_load_req;
  } lsu_bus_req_t;

  typedef struct packed {
    logic            ready;
    logic [1:0][31:0] rdata;
  } lsu_bus_resp_t;

  typedef struct packed {
    logic [19:0] p;
    logic        rp;
  } cache_tag_t;

  typedef struct packed {
    logic [11:0]      daddr;
    logic [1:0]       dway;
    logic             dwe;
    logic [3:0][31:0] d;
    logic [11:0]      taddr;
    logic [3:0]       twe;
    cache_tag_t       t;
  } dsram_snoop_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_WB,
    S_RESP
  } icache_refill_fsm_t;

endpackage

// File: rtl/wired_icache_refill.sv
// Instruction-cache miss / uncached-fetch responder: refills 16-byte lines over
// AXI4, installs them via the snoop/write port, and returns the requested doubleword.
module wired_icache_refill
  import wired0_defines::*;
#(
  parameter logic [3:0] AXI_ID  = 4'd0,
  parameter int         WAY_CNT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  lsu_bus_req_t  bus_req_i,
  output lsu_bus_resp_t bus_resp_o,
  output dsram_snoop_t  snoop_o,
  output logic [31:0]   araddr_o,
  output logic [7:0]    arlen_o,
  output logic [2:0]    arsize_o,
  output logic [1:0]    arburst_o,
  output logic [3:0]    arid_o,
  output logic          arvalid_o,
  input  logic          arready_i,
  input  logic [31:0]   rdata_i,
  input  logic [1:0]    rresp_i,
  input  logic          rlast_i,
  input  logic          rvalid_i,
  output logic          rready_o
);

  localparam int VW = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;

  icache_refill_fsm_t r_state;
  icache_refill_fsm_t w_next;

  logic [31:3]      r_paddr;
  logic             r_cached;
  logic [31:0]      r_araddr;
  logic [7:0]       r_arlen;
  logic [3:0][31:0] r_line;
  logic [1:0]       r_beat;
  logic [VW-1:0]    r_victim;
  logic             r_err;
  logic [11:0]      r_snaddr;

  logic w_is_cached;
  logic w_accept;

  // Cached allocation takes priority if a requester ever raises both flags.
  assign w_is_cached = (bus_req_i.inv_req == RD_ALLOC);
  assign w_accept    = bus_req_i.valid && (w_is_cached || bus_req_i.uncached_load_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_AR;
      S_AR:   if (arready_i) w_next = S_R;
      S_R:    if (rvalid_i && rlast_i) w_next = r_cached ? S_WB : S_RESP;
      S_WB:   w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_paddr  <= '0;
      r_cached <= 1'b0;
      r_araddr <= '0;
      r_arlen  <= '0;
      r_line   <= '0;
      r_beat   <= '0;
      r_victim <= '0;
      r_err    <= 1'b0;
      r_snaddr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_paddr  <= bus_req_i.target_paddr[31:3];
            r_cached <= w_is_cached;
            if (w_is_cached) begin
              r_araddr <= {bus_req_i.target_paddr[31:4], 4'h0};
              r_arlen  <= 8'd3;
              r_beat   <= 2'd0;
            end else begin
              r_araddr <= bus_req_i.target_paddr;
              r_arlen  <= (bus_req_i.size == 2'd3) ? 8'd1 : 8'd0;
              // Uncached beats land in the word slot matching the address.
              r_beat   <= {1'b0, bus_req_i.target_paddr[2]};
            end
          end
        end
        S_R: begin
          if (rvalid_i) begin
            r_line[r_beat] <= rdata_i;
            r_beat         <= r_beat + 2'd1;
            if (rresp_i != RESP_OKAY) r_err <= 1'b1;
            if (rlast_i && r_cached) r_snaddr <= {r_paddr[11:4], 4'h0};
          end
        end
        S_WB: begin
          r_victim <= (r_victim == VW'(WAY_CNT - 1)) ? '0 : r_victim + 1'b1;
        end
        S_RESP: r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    arvalid_o = (r_state == S_AR);
    rready_o  = (r_state == S_R);
    araddr_o  = r_araddr;
    arlen_o   = r_arlen;
    arsize_o  = 3'd2;
    arburst_o = BURST_INCR;
    arid_o    = AXI_ID;

    bus_resp_o       = '0;
    bus_resp_o.ready = (r_state == S_RESP);
    if (r_cached) bus_resp_o.rdata = {r_line[{r_paddr[3], 1'b1}], r_line[{r_paddr[3], 1'b0}]};
    else          bus_resp_o.rdata = {r_line[1], r_line[0]};

    // Addresses hold between writebacks so downstream comparators stay quiet.
    snoop_o       = '0;
    snoop_o.daddr = r_snaddr;
    snoop_o.taddr = r_snaddr;
    snoop_o.dway  = 2'(r_victim);
    snoop_o.dwe   = (r_state == S_WB);
    snoop_o.d     = r_line;
    for (int i = 0; i < 4; i++) begin
      snoop_o.twe[i] = (r_state == S_WB) && (r_victim == VW'(i));
    end
    snoop_o.t.p  = r_paddr[31:12];
    snoop_o.t.rp = !r_err;
  end

endmodule
